apb_s: RTL and testbench
========================

# apb_s

APB completer (slave) serving a DEPTH-entry register file with a programmable number of wait states and error response for out-of-range addresses. It answers the transfers issued by the team's APB initiator (`apb_m`) and sits on the peripheral side of the same APB link. All responses are driven from a small FSM plus a wait-state counter.

## Interface
- ADDR_W, 4, width of `paddr`.
- DATA_W, 8, width of `pwdata`/`prdata`.
- DEPTH, 12, number of implemented registers; addresses `>= DEPTH` are errors. Legal range 1..2^ADDR_W.
- WAIT_STATES, 1, number of access-phase cycles with `pready=0` before completion. Legal range 0..15.
- pclk  in  1  clock; all state changes on rising edge.
- preset  in  1  reset; asynchronous, active-high.
- psel  in  1  select from initiator.
- penable  in  1  access-phase strobe.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  register index.
- pwdata  in  DATA_W  write data.
- pready  out  1  transfer complete.
- prdata  out  DATA_W  read data.
- pslverr  out  1  error on completing transfer.

## Operation
- Reset: state=IDLE, wait counter=0, all registers=0. `pready=0`, `prdata=0`, `pslverr=0` while `preset` is high and in the first cycle after release.
- FSM states:
  - IDLE: on `psel & ~penable` (setup phase), load counter=WAIT_STATES and go to ACCESS. `penable` without `psel`, or `psel & penable` in IDLE (no setup seen), is ignored and the FSM stays in IDLE.
  - ACCESS: if `psel=0`, abort: go to IDLE with no write. Otherwise, while counter≠0 and `penable=1`, decrement the counter. When counter==0, `pready=1`. At the edge where `psel & penable & pready`, commit and go to IDLE.
- Commit:
  - A write with `paddr < DEPTH` stores `pwdata` into `reg[paddr]`.
  - A write with `paddr >= DEPTH` changes nothing.
  - A read changes nothing.
- Outputs are combinational from state, counter and inputs:
  - `pready = (state==ACCESS) & (counter==0)`.
  - `pslverr = pready & (paddr >= DEPTH)`.
  - `prdata = reg[paddr]` when `pready & ~pwrite & (paddr < DEPTH)`, else 0.
- `paddr`, `pwrite`, `pwdata` are sampled only during ACCESS. The initiator holds them stable from setup to completion; the block does not latch them.
- Counter width is 4 bits; no wrap, since it only counts down to 0.

## Timing
- Setup cycle T0 (`psel=1, penable=0`). Access begins at T1.
- `pready` rises in cycle T1+WAIT_STATES. With WAIT_STATES=0, `pready=1` in T1.
- The write takes effect at the rising edge ending the `pready` cycle. A read in the next transfer returns the new value.
- Back-to-back transfers: the cycle after completion is IDLE, so a new setup phase there is accepted. There are no dead cycles beyond APB's mandatory setup phase.
- Reset asserted mid-ACCESS forces IDLE immediately (asynchronously): `pready` drops, the in-flight write is lost, and registers clear.
- An abort (`psel` drops in ACCESS) returns to IDLE at the next edge. `pready` is never asserted for the aborted transfer.

## Structure
- Shared package `apb_pkg`:
  - state enum `apb_s_state_t` {IDLE, ACCESS}.
  - default ADDR_W and DATA_W constants.
  - WAIT_CNT_W=4.
- One sub-module, `apb_s_regfile`:
  - DEPTH×DATA_W storage with async clear.
  - write port (`we`, `waddr`, `wdata`).
  - combinational read port.
- The FSM, counter and response logic stay in `apb_s`.

## Test plan
- Reset, then WAIT_STATES=1: write `paddr=3, pwdata=A5` -> `pready` high in T2, `pslverr=0`. Subsequent read of addr 3 -> `prdata=A5` in its `pready` cycle, and 0 in all other cycles.
- Write `paddr=13`, data `5A` (DEPTH=12) -> `pready` with `pslverr=1`. Read addr 13 -> `pslverr=1`, `prdata=0`. All registers are unchanged.
- WAIT_STATES=0: back-to-back writes to addr 0 (11) and addr 1 (22) with no idle cycles, then reads -> `pready` in each T1, readback 11 and 22.
- Assert `preset` during the wait cycle of a write to addr 5 (`pwdata=FF`) -> `pready` is never seen for it; after release, read of addr 5 returns 00.
- Drop `psel` in ACCESS before `pready` on a write to addr 2 (`pwdata=77`) -> FSM is in IDLE the next cycle; read of addr 2 returns 00.
- `psel=1, penable=1` presented without a prior setup cycle -> `pready` stays 0 and no register changes.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: completer FSM state encoding and default bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

  localparam int APB_ADDR_W = 4;
  localparam int APB_DATA_W = 8;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_s_state_t;

endpackage

// File: rtl/apb_s_regfile.sv
// DEPTH x DATA_W register storage, one synchronous write port, one combinational read port.
// Latency: write visible on the read port the cycle after we is sampled; read is same-cycle.
// Backpressure: none; every write is accepted.
//
// Ports:
//   clk, rst       clock and asynchronous active-high clear of every entry
//   we/waddr/wdata write port; writes to addresses >= DEPTH are dropped
//   raddr/rdata    combinational read; addresses >= DEPTH read as 0
module apb_s_regfile
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W,
  parameter int DEPTH  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic waddr_ok;
  logic raddr_ok;

  // Widen to 32 bits before comparing so DEPTH == 2^ADDR_W still works.
  assign waddr_ok = (32'(waddr) < DEPTH);
  assign raddr_ok = (32'(raddr) < DEPTH);

  always_comb begin
    mem_d = mem_q;
    if (we && waddr_ok) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = raddr_ok ? mem_q[raddr] : '0;

endmodule

// File: rtl/apb_s.sv
// APB completer serving a DEPTH-entry register file, with WAIT_STATES access wait cycles and
// an error response for out-of-range addresses.
// Latency: pready in access cycle WAIT_STATES (0 = first access cycle); write commits on that edge.
// Backpressure: pready held low for WAIT_STATES access cycles; the initiator holds the bus until it rises.
//
// Ports:
//   pclk, preset                    clock, asynchronous active-high reset
//   psel, penable, pwrite           APB control from the initiator
//   paddr, pwdata                   register index and write data, held stable by the initiator
//   pready, prdata, pslverr         combinational response
module apb_s
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);

  apb_s_state_t          state_q;
  apb_s_state_t          state_d;
  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;

  logic              addr_ok;
  logic              reg_we;
  logic [DATA_W-1:0] reg_rdata;

  assign addr_ok = (32'(paddr) < DEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    reg_we  = 1'b0;
    case (state_q)
      IDLE: begin
        // Only a proper setup phase starts a transfer; a lone penable or an
        // access phase without setup is ignored.
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = WAIT_CNT_W'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!psel) begin
          // Abort: drop the transfer without touching the register file.
          state_d = IDLE;
        end else if (penable && pready) begin
          state_d = IDLE;
          reg_we  = pwrite && addr_ok;
        end else if (penable && (cnt_q != '0)) begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pready  = (state_q == ACCESS) && (cnt_q == '0);
  assign pslverr = pready && !addr_ok;
  assign prdata  = (pready && !pwrite && addr_ok) ? reg_rdata : '0;

  apb_s_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk   (pclk),
    .rst   (preset),
    .we    (reg_we),
    .waddr (paddr),
    .wdata (pwdata),
    .raddr (paddr),
    .rdata (reg_rdata)
  );

endmodule

// File: tb/tb_apb_s.sv
module tb_apb_s;

  localparam int DEPTH = 12;

  logic       pclk;
  logic       preset;
  logic       psel    [2];
  logic       penable [2];
  logic       pwrite  [2];
  logic [3:0] paddr   [2];
  logic [7:0] pwdata  [2];
  logic       pready  [2];
  logic [7:0] prdata  [2];
  logic       pslverr [2];

  // Instance 0 runs with one wait state, instance 1 with none.
  apb_s #(.ADDR_W(4), .DATA_W(8), .DEPTH(DEPTH), .WAIT_STATES(1)) u_dut0 (
    .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
    .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]));

  apb_s #(.ADDR_W(4), .DATA_W(8), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut1 (
    .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
    .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    int         cyc;
    logic       err;
    logic [7:0] rd;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] mdl [2][16];
  int         cyc;
  int         n_checks;
  int         n_fail;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 16; a++) mdl[d][a] = 8'h00;
  endtask

  // Monitor: pops the expected response whenever a DUT presents pready.
  always @(negedge pclk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      if (preset) begin
        check($sformatf("rst_pready%0d", d), int'(pready[d]), 0);
        check($sformatf("rst_prdata%0d", d), int'(prdata[d]), 0);
      end else if (pready[d]) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          check($sformatf("unexpected_pready%0d", d), 1, 0);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("pready_cycle%0d", d), cyc, e.cyc);
          check($sformatf("pslverr%0d", d), int'(pslverr[d]), int'(e.err));
          check($sformatf("prdata%0d", d), int'(prdata[d]), int'(e.rd));
        end
      end else begin
        check($sformatf("idle_prdata%0d", d), int'(prdata[d]), 0);
        check($sformatf("idle_pslverr%0d", d), int'(pslverr[d]), 0);
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  // mode 0: normal transfer, 1: abort in first access cycle, 2: reset during first access cycle.
  task automatic xfer(input int d, input logic wr, input logic [3:0] a,
                      input logic [7:0] wd, input int mode);
    exp_t e;
    int   waits;
    bit   done;
    waits = (d == 0) ? 1 : 0;
    psel[d] = 1'b1; penable[d] = 1'b0;
    pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    if (mode == 0) begin
      e.cyc = cyc + 1 + waits;
      e.err = (a >= DEPTH);
      e.rd  = (!wr && a < DEPTH) ? mdl[d][a] : 8'h00;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      if (wr && a < DEPTH) mdl[d][a] = wd;
    end
    @(posedge pclk); #1;
    if (mode == 1) begin
      psel[d] = 1'b0; penable[d] = 1'b0;
      @(posedge pclk); #1;
      return;
    end
    penable[d] = 1'b1;
    if (mode == 2) begin
      #2 preset = 1'b1;
      model_clear();
      @(posedge pclk); #1;
      psel[d] = 1'b0; penable[d] = 1'b0;
      @(negedge pclk);
      preset = 1'b0;
      @(posedge pclk); #1;
      return;
    end
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge pclk);
      if (pready[d]) done = 1;
    end
    if (!done) check($sformatf("timeout%0d", d), 0, 1);
    @(posedge pclk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0;
    end
    repeat (n) begin
      @(posedge pclk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0;
    preset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; penable[d] = 0; pwrite[d] = 0; paddr[d] = 0; pwdata[d] = 0;
    end
    model_clear();
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    @(posedge pclk); #1;
    idle(1);

    // Single-wait write then readback, out-of-range write/read.
    xfer(0, 1, 4'd3, 8'hA5, 0);
    idle(1);
    xfer(0, 0, 4'd3, 8'h00, 0);
    xfer(0, 1, 4'd13, 8'h5A, 0);
    xfer(0, 0, 4'd13, 8'h00, 0);
    for (int a = 0; a < DEPTH; a++) xfer(0, 0, 4'(a), 8'h00, 0);

    // Zero-wait back-to-back writes and reads.
    xfer(1, 1, 4'd0, 8'h11, 0);
    xfer(1, 1, 4'd1, 8'h22, 0);
    xfer(1, 0, 4'd0, 8'h00, 0);
    xfer(1, 0, 4'd1, 8'h00, 0);
    idle(2);

    // Reset during the wait cycle of a write; everything clears.
    xfer(0, 1, 4'd5, 8'hFF, 2);
    xfer(0, 0, 4'd5, 8'h00, 0);
    xfer(1, 0, 4'd0, 8'h00, 0);

    // Abort before pready.
    xfer(0, 1, 4'd2, 8'h77, 1);
    xfer(0, 0, 4'd2, 8'h00, 0);

    // Access phase without a setup phase is ignored.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
    paddr[0] = 4'd4; pwdata[0] = 8'h99;
    repeat (4) begin
      @(posedge pclk); #1;
    end
    idle(1);
    xfer(0, 0, 4'd4, 8'h00, 0);

    // Randomized traffic on both instances, with occasional back-to-back transfers.
    for (int i = 0; i < 150; i++) begin
      int d;
      d = int'($urandom_range(0, 1));
      xfer(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)), 0);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    for (int a = 0; a < 16; a++) begin
      xfer(0, 0, 4'(a), 8'h00, 0);
      xfer(1, 0, 4'(a), 8'h00, 0);
    end
    idle(3);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
